// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//
// Contents:
//   DEFAULT_WIDTH - default operand width for serial units
//   state_e       - FSM state encoding shared by the serial adder/subtractor
//                   (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2)
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor stage: di = xi - yi - bi, with borrow out.
//
// Ports:
//   xi - minuend bit
//   yi - subtrahend bit
//   bi - borrow in
//   di - difference bit
//   bo - borrow out
module full_subtractor (
    input  logic xi,
    input  logic yi,
    input  logic bi,
    output logic di,
    output logic bo
);

    assign di = xi ^ yi ^ bi;
    // Borrow when yi exceeds xi outright, or when they are equal and a
    // borrow is already pending from the lower bit.
    assign bo = (~xi & yi) | (~(xi ^ yi) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes x - y (mod 2^WIDTH) one bit per clock,
// LSB first, through a single full_subtractor stage and a borrow flop.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches x/y.
// The operation then takes WIDTH SHIFT cycles; done pulses for one cycle
// while d/bout become valid, and d/bout hold until the next accepted start.
// start during SHIFT or DONE is ignored and never queued.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - operation request (IDLE only)
//   x, y  - minuend / subtrahend, captured on accepted start
//   busy  - high while in SHIFT
//   done  - one-cycle pulse when results are valid
//   d     - difference, held
//   bout  - final borrow (x < y unsigned), held
//   ovf   - signed overflow, only when SERIAL_SUB_OVF_EN is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] ds_q, ds_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             di, bo;
    logic [WIDTH-1:0] ds_shift;

    full_subtractor u_stage (
        .xi (xs_q[0]),
        .yi (ys_q[0]),
        .bi (borrow_q),
        .di (di),
        .bo (bo)
    );

    // Difference bits enter at the top so that after WIDTH shifts the
    // first (LSB) result bit has reached position 0.
    assign ds_shift = {di, ds_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        ds_d     = ds_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    xs_d     = x;
                    ys_d     = y;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_SHIFT: begin
                xs_d     = xs_q >> 1;
                ys_d     = ys_q >> 1;
                ds_d     = ds_shift;
                borrow_d = bo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    d_d     = ds_shift;
                    bout_d  = bo;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB stage differing from borrow out
                    // of it is exactly the signed overflow condition.
                    ovf_d   = borrow_q ^ bo;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            ds_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            ds_q     <= ds_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_serial_subtractor;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x, y, d;
    logic         busy, done, bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];   // {ovf, bout, d}
    logic [W+1:0] last_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb, sr, modv, half;
        logic [W-1:0] dd;
        logic bb, oo;
        ua   = longint'(a);
        ub   = longint'(b);
        modv = longint'(1) << W;
        half = longint'(1) << (W - 1);
        dd   = W'((ua - ub + modv) % modv);
        bb   = (ua < ub);
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        sr   = sa - sb;
        oo   = (sr < -half) || (sr > half - 1);
        return {oo, bb, dd};
    endfunction

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, ".d"}, 32'(d), 32'(e[W-1:0]));
        check({tag, ".bout"}, 32'(bout), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with the DUT in IDLE. noise randomizes
    // start/x/y during the operation; pulse_at injects a start pulse with
    // x=0x10, y=0x20 in that busy cycle.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input int pulse_at);
        start = 1'b1;
        x     = a;
        y     = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy0"}, 32'(busy), 32'd1);
        check({tag, ".done0"}, 32'(done), 32'd0);
        for (int k = 1; k <= W; k++) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                x     = W'($urandom);
                y     = W'($urandom);
            end else if (k == pulse_at) begin
                start = 1'b1;
                x     = 8'h10;
                y     = 8'h20;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k < W) begin
                check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
                check($sformatf("%s.done%0d", tag, k), 32'(done), 32'd0);
            end
        end
        check({tag, ".done_pulse"}, 32'(done), 32'd1);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            last_exp = exp_q.pop_front();
            check_result(tag, last_exp);
        end
        start = 1'b0;
        @(negedge clk);
        check({tag, ".done_drop"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check_result({tag, ".hold"}, last_exp);
    endtask

    // ---------------- stimulus ----------------
    int done_cyc[$];
    int seen_done;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_result("reset", '0);
        rst = 1'b0;
        @(negedge clk);

        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 0);
        check("op5a3c.value", 32'(d), 32'h1E);
        run_op("op0001", 8'h00, 8'h01, 1'b0, 0);
        run_op("op8001", 8'h80, 8'h01, 1'b0, 0);
        run_op("opa5a5", 8'hA5, 8'hA5, 1'b0, 3);
        check("opa5a5.ignored", 32'(d), 32'h00);
        run_op("op1020", 8'h10, 8'h20, 1'b0, 0);
        check("op1020.value", 32'(d), 32'hF0);

        // Reset in the middle of an operation.
        start = 1'b1;
        x     = 8'hFF;
        y     = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check_result("abort", '0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
        run_op("op0f0f", 8'h0F, 8'h0F, 1'b0, 0);

        // Reset and start together: start dropped.
        rst   = 1'b1;
        start = 1'b1;
        x     = 8'h01;
        y     = 8'h02;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start.busy2", 32'(busy), 32'd0);

        // Randomized operations with noise on start/x/y while busy.
        for (int n = 0; n < 20; n++) begin
            run_op($sformatf("rand%0d", n), W'($urandom), W'($urandom), 1'b1, 0);
        end

        // start held high: back-to-back operations every W+2 cycles.
        start = 1'b1;
        x     = 8'h03;
        y     = 8'h02;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done) begin
                done_cyc.push_back(cyc);
                check("b2b.d", 32'(d), 32'h01);
                check("b2b.bout", 32'(bout), 32'd0);
            end
        end
        start = 1'b0;
        check("b2b.count", 32'(done_cyc.size()), 32'd3);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("b2b.spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(W + 2));
        end
        for (int i = 0; i < W + 2 && (busy || done); i++) @(negedge clk);
        check("b2b.idle", 32'(busy | done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
